// File: rtl/avalon_bus_arbiter_if.sv
// rtl/avalon_bus_arbiter_if.sv - Avalon-MM master port bundle shared by fetch and data paths
interface avalon_bus_arbiter_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/avalon_bus_arbiter.sv
// rtl/avalon_bus_arbiter.sv - round-robin fetch/data arbiter onto one Avalon-MM master with stall watchdog
module avalon_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ifetch_req,
  input  logic [31:0]                 ifetch_addr,
  output logic [31:0]                 ifetch_rdata,
  output logic                        ifetch_ack,
  input  logic                        data_req,
  input  logic                        data_we,
  input  logic [31:0]                 data_addr,
  input  logic [31:0]                 data_wdata,
  input  logic [3:0]                  data_byteenable,
  output logic [31:0]                 data_rdata,
  output logic                        data_ack,
  output logic                        bus_error,
  avalon_bus_arbiter_if.master        bus
);

  typedef enum logic [1:0] {IDLE, BUS_FETCH, BUS_DATA, ACK} state_t;

  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic        last_grant_data;
  logic [31:0] addr_r;
  logic [3:0]  be_r;
  logic        we_r;
  logic [31:0] wdata_r;
  logic [15:0] stall_cnt;
  logic        err_r;
  logic        grant_fetch;
  logic        grant_data;
  logic        in_bus;
  logic        done;
  logic        abort;

  // Contested requests go to whoever did not win last time.
  always_comb begin
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    if (state == IDLE) begin
      if (ifetch_req && data_req) begin
        grant_data  = !last_grant_data;
        grant_fetch = last_grant_data;
      end else begin
        grant_fetch = ifetch_req;
        grant_data  = data_req;
      end
    end
  end

  assign in_bus = (state == BUS_FETCH) || (state == BUS_DATA);
  assign done   = in_bus && !bus.waitrequest;
  assign abort  = in_bus && bus.waitrequest && (stall_cnt == STALL_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_data)       state_next = BUS_DATA;
        else if (grant_fetch) state_next = BUS_FETCH;
      end
      BUS_FETCH, BUS_DATA: if (done || abort) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_data <= 1'b0;
      addr_r          <= 32'h0;
      be_r            <= 4'h0;
      we_r            <= 1'b0;
      wdata_r         <= 32'h0;
      stall_cnt       <= 16'h0;
      err_r           <= 1'b0;
      ifetch_rdata    <= 32'h0;
      data_rdata      <= 32'h0;
    end else begin
      if (grant_fetch || grant_data) last_grant_data <= grant_data;
      if (grant_fetch) begin
        addr_r  <= ifetch_addr & ~32'h3;
        be_r    <= 4'hF;
        we_r    <= 1'b0;
        wdata_r <= 32'h0;
      end else if (grant_data) begin
        addr_r  <= data_addr & ~32'h3;
        be_r    <= data_byteenable;
        we_r    <= data_we;
        wdata_r <= data_we ? data_wdata : 32'h0;
      end
      if (!in_bus)               stall_cnt <= 16'h0;
      else if (bus.waitrequest)  stall_cnt <= stall_cnt + 16'h1;
      if (in_bus) err_r <= abort;
      // An aborted transfer hands back zero so the core never consumes stale data.
      if (abort) begin
        if (state == BUS_FETCH) ifetch_rdata <= 32'h0;
        else                    data_rdata   <= 32'h0;
      end else if (done && !we_r) begin
        if (state == BUS_FETCH) ifetch_rdata <= bus.readdata;
        else                    data_rdata   <= bus.readdata;
      end
    end
  end

  always_comb begin
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = 32'h0;
    bus.writedata  = 32'h0;
    bus.byteenable = 4'h0;
    ifetch_ack     = 1'b0;
    data_ack       = 1'b0;
    bus_error      = 1'b0;
    case (state)
      BUS_FETCH, BUS_DATA: begin
        bus.read       = !we_r;
        bus.write      = we_r;
        bus.address    = addr_r;
        bus.writedata  = wdata_r;
        bus.byteenable = be_r;
      end
      ACK: begin
        ifetch_ack = !last_grant_data;
        data_ack   = last_grant_data;
        bus_error  = err_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// tb/tb_avalon_bus_arbiter.sv - scoreboard bench for avalon_bus_arbiter with randomized requesters and slave
module tb_avalon_bus_arbiter;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ifetch_req = 1'b0;
  logic [31:0] ifetch_addr = 32'h0;
  logic [31:0] ifetch_rdata;
  logic        ifetch_ack;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic [3:0]  data_byteenable = 4'h0;
  logic [31:0] data_rdata;
  logic        data_ack;
  logic        bus_error;

  avalon_bus_arbiter_if bus_if ();

  avalon_bus_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_rdata(ifetch_rdata), .ifetch_ack(ifetch_ack),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_byteenable(data_byteenable), .data_rdata(data_rdata), .data_ack(data_ack),
    .bus_error(bus_error), .bus(bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    logic [31:0] addr;
    logic [3:0]  be;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          strobes;
  } exp_t;

  typedef struct {
    int          waits;
    logic [31:0] rd;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;
  bit    in_x = 1'b0;

  // Reference model state: who won last, and what each requester last read back.
  bit          last_data = 1'b0;
  logic [31:0] prev_f = 32'h0;
  logic [31:0] prev_d = 32'h0;

  logic [31:0] f_addr_v, f_rd_v, d_addr_v, d_wdata_v, d_rd_v;
  logic [3:0]  d_be_v;
  bit          d_we_v;
  int          f_waits_v, d_waits_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_xfer(input bit is_data);
    exp_t        e;
    plan_t       p;
    logic [31:0] a;
    p.waits   = is_data ? d_waits_v : f_waits_v;
    p.rd      = is_data ? d_rd_v : f_rd_v;
    a         = is_data ? d_addr_v : f_addr_v;
    e.is_data = is_data;
    e.addr    = a & 32'hFFFF_FFFC;
    e.be      = is_data ? d_be_v : 4'hF;
    e.we      = is_data && d_we_v;
    e.wdata   = e.we ? d_wdata_v : 32'h0;
    e.err     = (p.waits >= TIMEOUT);
    e.strobes = e.err ? TIMEOUT : p.waits + 1;
    if (e.err)     e.rdata = 32'h0;
    else if (e.we) e.rdata = prev_d;
    else           e.rdata = p.rd;
    if (is_data) prev_d = e.rdata;
    else         prev_f = e.rdata;
    last_data = is_data;
    exp_q.push_back(e);
    plan_q.push_back(p);
  endtask

  task automatic wait_ack(input bit is_data);
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = is_data ? data_ack : ifetch_ack;
    end
    if (is_data) check("data_ack_seen", 32'(got), 32'd1);
    else         check("ifetch_ack_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    if (is_data) data_req = 1'b0;
    else         ifetch_req = 1'b0;
  endtask

  task automatic drive_fetch();
    ifetch_addr = f_addr_v;
    ifetch_req  = 1'b1;
    wait_ack(1'b0);
  endtask

  task automatic drive_data();
    data_addr       = d_addr_v;
    data_we         = d_we_v;
    data_wdata      = d_wdata_v;
    data_byteenable = d_be_v;
    data_req        = 1'b1;
    wait_ack(1'b1);
  endtask

  // mode: 0 fetch, 1 data, 2 both same cycle, 3 fetch then data, 4 data then fetch
  task automatic run_round(input int mode);
    bit data_first;
    case (mode)
      0: push_xfer(1'b0);
      1: push_xfer(1'b1);
      2: begin
        data_first = !last_data;
        push_xfer(data_first);
        push_xfer(!data_first);
      end
      3: begin push_xfer(1'b0); push_xfer(1'b1); end
      default: begin push_xfer(1'b1); push_xfer(1'b0); end
    endcase
    @(negedge clk);
    case (mode)
      0: drive_fetch();
      1: drive_data();
      2: fork drive_fetch(); drive_data(); join
      3: fork drive_fetch(); begin @(negedge clk); drive_data(); end join
      default: fork drive_data(); begin @(negedge clk); drive_fetch(); end join
    endcase
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_fields(input logic [31:0] fa, input logic [31:0] frd, input int fw,
                            input logic [31:0] da, input bit dwe, input logic [31:0] dwd,
                            input logic [3:0] dbe, input logic [31:0] drd, input int dw);
    f_addr_v = fa; f_rd_v = frd; f_waits_v = fw;
    d_addr_v = da; d_we_v = dwe; d_wdata_v = dwd; d_be_v = dbe; d_rd_v = drd; d_waits_v = dw;
  endtask

  initial begin : slave
    plan_t       p;
    bit          act = 1'b0;
    int          rem = 0;
    logic [31:0] rd = 32'h0;
    bus_if.waitrequest = 1'b0;
    bus_if.readdata    = 32'h0;
    forever begin
      @(negedge clk);
      if (bus_if.read || bus_if.write) begin
        if (!act) begin
          act = 1'b1;
          if (plan_q.size() > 0) p = plan_q.pop_front();
          else begin p.waits = 0; p.rd = 32'h0; end
          rem = p.waits;
          rd  = p.rd;
        end else begin
          rem--;
        end
        bus_if.waitrequest = (rem > 0);
        bus_if.readdata    = (rem > 0) ? $urandom : rd;
      end else begin
        act = 1'b0;
        bus_if.waitrequest = 1'($urandom);
        bus_if.readdata    = $urandom;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    int   scnt = 0;
    e = '{default: 0};
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("rd_wr_excl", 32'(bus_if.read & bus_if.write), 32'd0);
        check("ack_excl", 32'(ifetch_ack & data_ack), 32'd0);
        if (bus_if.read || bus_if.write) begin
          if (!in_x) begin
            in_x = 1'b1;
            scnt = 0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else begin
              check("unexpected_xfer", 32'd1, 32'd0);
              e = '{default: 0};
            end
          end
          scnt++;
          check("address", bus_if.address, e.addr);
          check("byteenable", 32'(bus_if.byteenable), 32'(e.be));
          check("write", 32'(bus_if.write), 32'(e.we));
          check("read", 32'(bus_if.read), 32'(!e.we));
          if (e.we || !e.is_data) check("writedata", bus_if.writedata, e.wdata);
        end else if (in_x) begin
          in_x = 1'b0;
          check("strobe_cycles", 32'(scnt), 32'(e.strobes));
          check("ifetch_ack", 32'(ifetch_ack), 32'(!e.is_data));
          check("data_ack", 32'(data_ack), 32'(e.is_data));
          check("bus_error", 32'(bus_error), 32'(e.err));
          if (e.is_data) check("data_rdata", data_rdata, e.rdata);
          else           check("ifetch_rdata", ifetch_rdata, e.rdata);
        end else begin
          check("idle_ack_err", {29'h0, ifetch_ack, data_ack, bus_error}, 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    bit seen;
    int w;
    repeat (2) @(negedge clk);
    check("rst_read", 32'(bus_if.read), 32'd0);
    check("rst_write", 32'(bus_if.write), 32'd0);
    check("rst_address", bus_if.address, 32'h0);
    check("rst_writedata", bus_if.writedata, 32'h0);
    check("rst_byteenable", 32'(bus_if.byteenable), 32'h0);
    check("rst_ifetch_ack", 32'(ifetch_ack), 32'd0);
    check("rst_data_ack", 32'(data_ack), 32'd0);
    check("rst_ifetch_rdata", ifetch_rdata, 32'h0);
    check("rst_data_rdata", data_rdata, 32'h0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Contested pairs right after reset: data first, then fetch first.
    set_fields(32'h0000_0100, 32'h1111_1111, 0, 32'h0000_0200, 1'b0, 32'h0, 4'hF, 32'h2222_2222, 1);
    run_round(2);
    set_fields(32'h0000_0104, 32'h3333_3333, 2, 32'h0000_0204, 1'b1, 32'h4444_4444, 4'hC, 32'h0, 0);
    run_round(2);
    set_fields(32'h0000_0004, 32'h2402_0010, 0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 0);
    run_round(0);
    set_fields(32'h0, 32'h0, 0, 32'h0000_0300, 1'b0, 32'h0, 4'hF, 32'hCAFE_F00D, 1);
    run_round(1);
    set_fields(32'h0, 32'h0, 0, 32'h0000_1003, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h0, 3);
    run_round(1);
    set_fields(32'h0000_0040, 32'h5555_5555, 100, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 0);
    run_round(0);
    set_fields(32'h0000_0044, 32'h6666_6666, 0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 0);
    run_round(0);
    set_fields(32'h0, 32'h0, 0, 32'h0000_0404, 1'b0, 32'h0, 4'h3, 32'h7777_7777, 4);
    run_round(1);

    for (int r = 0; r < 40; r++) begin
      w = ($urandom % 8 == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
      set_fields($urandom, $urandom, w, $urandom, 1'($urandom), $urandom, 4'($urandom), $urandom,
                 int'($urandom_range(0, 4)));
      run_round(int'($urandom_range(0, 4)));
    end

    // Reset in the second cycle of a stalled write; a held fetch must then be served alone.
    mon_en = 1'b0;
    plan_q.push_back('{waits: 50, rd: 32'h0});
    data_addr = 32'h0000_2004; data_we = 1'b1; data_wdata = 32'h1234_5678; data_byteenable = 4'hF;
    data_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus_if.write;
    end
    check("rst_test_write_start", 32'(seen), 32'd1);
    ifetch_addr = 32'h0000_0080;
    ifetch_req  = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_write", 32'(bus_if.write), 32'd0);
    check("async_rst_read", 32'(bus_if.read), 32'd0);
    check("async_rst_address", bus_if.address, 32'h0);
    check("async_rst_ifetch_ack", 32'(ifetch_ack), 32'd0);
    check("async_rst_data_ack", 32'(data_ack), 32'd0);
    data_req  = 1'b0;
    last_data = 1'b0;
    prev_f    = 32'h0;
    prev_d    = 32'h0;
    set_fields(32'h0000_0080, 32'h8888_8888, 1, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 0);
    push_xfer(1'b0);
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_ack(1'b0);
    repeat (3) @(negedge clk);
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/avalon_bus_arbiter.md
Name: avalon_bus_arbiter

Overview:
Shares the CPU's single Avalon memory-mapped master port between two requesters: the instruction-fetch path (read-only) and the load/store data path (read/write). It arbitrates between them, sequences one Avalon transfer at a time, honours waitrequest, and returns read data with a one-cycle acknowledge pulse. A watchdog aborts any transfer that stalls too long. It sits between the top_level_cpu core logic and the RAM/bus.

Parameters:
TIMEOUT_CYCLES, 255, maximum consecutive waitrequest-high cycles before a transfer is aborted (range 1..65535).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ifetch_req  input  1  fetch request, held high until ifetch_ack
ifetch_addr  input  32  fetch byte address
ifetch_rdata  output  32  fetched word, valid while ifetch_ack=1
ifetch_ack  output  1  one-cycle completion pulse for fetch
data_req  input  1  data request, held high until data_ack
data_we  input  1  1=write, 0=read
data_addr  input  32  data byte address
data_wdata  input  32  store data
data_byteenable  input  4  store/load lane enables
data_rdata  output  32  load data, valid while data_ack=1
data_ack  output  1  one-cycle completion pulse for data
bus_error  output  1  high with the ack of an aborted (timed-out) transfer
address  output  32  Avalon address
write  output  1  Avalon write strobe
read  output  1  Avalon read strobe
waitrequest  input  1  Avalon slave stall
writedata  output  32  Avalon write data
byteenable  output  4  Avalon byte enables
readdata  input  32  Avalon read data, valid in the cycle read=1 and waitrequest=0

Behaviour:
- States: IDLE, BUS_FETCH, BUS_DATA, ACK.
- Reset (asynchronous): state=IDLE, last_grant=FETCH, timeout counter=0. All outputs 0: read, write, address, writedata, byteenable, ifetch_ack, data_ack, ifetch_rdata, data_rdata, bus_error. Reset mid-transfer drops read/write immediately and discards the transfer without an ack.
- IDLE: req sampled at a rising edge. Only fetch pending -> BUS_FETCH. Only data pending -> BUS_DATA. Both pending -> grant the requester not in last_grant, so the first contested grant after reset goes to data. Update last_grant on every grant. No request -> stay in IDLE.
- Request fields (addr, we, wdata, byteenable) are registered on the grant edge. The bus outputs are driven from these registers for the whole transfer.
- BUS_FETCH: read=1, write=0, address={ifetch_addr[31:2],2'b00}, byteenable=4'hF, writedata=0.
- BUS_DATA: address={data_addr[31:2],2'b00}, byteenable=data_byteenable. If we=1, write=1 and writedata=data_wdata; otherwise read=1.
- Strobes and address are held constant while waitrequest=1.
- A transfer completes in the first BUS_* cycle with waitrequest=0. On that edge: readdata is captured into the granted requester's rdata (reads only), the strobes drop, and the state moves to ACK. For writes, rdata keeps its previous value.
- ACK: exactly one cycle. The granted requester's ack=1, the other ack=0. Then IDLE. Requesters drop req in the cycle after ack, so no duplicate transfer is issued.
- Minimum latency: req seen at edge E0, bus strobe active in cycle E0..E1, ack high in cycle E1..E2. That is 2 cycles request-to-ack with zero wait states. Each extra waitrequest cycle adds 1.
- Back-to-back: at least one IDLE cycle between transfers. Peak throughput is one transfer per 3 cycles.
- Timeout: the counter increments on each BUS_* cycle with waitrequest=1 and clears on entry to BUS_*.
  - When the counter reaches TIMEOUT_CYCLES with waitrequest still high, the strobes drop, the state moves to ACK, and bus_error=1 during that ACK.
  - The aborted requester's rdata becomes 32'h0.
  - bus_error=0 in every other cycle.
- read and write are never both 1. At most one ack is high in any cycle.
- A req that drops before its ack is a requester protocol violation; behaviour is undefined.

Test Plan:
- Single fetch, waitrequest=0, readdata=32'h24020010, ifetch_addr=32'h04: read=1 at address 32'h04 for one cycle; ifetch_ack pulses 2 cycles after req with ifetch_rdata=32'h24020010; data_ack stays 0.
- Data write, data_addr=32'h1003 (unaligned), wdata=32'hDEADBEEF, byteenable=4'b0011, waitrequest high for 3 cycles: write held 4 cycles at address 32'h1000 with byteenable=4'b0011; data_ack 5 cycles after req; data_rdata unchanged.
- Fetch and data requested in the same cycle after reset: data is served first, then fetch. A second simultaneous pair is served fetch first, then data, confirming the round-robin alternation.
- waitrequest stuck high, TIMEOUT_CYCLES=4: read drops after 4 stall cycles; ack pulses with bus_error=1 and rdata=0. The next transfer with waitrequest=0 completes with bus_error=0.
- Reset asserted in the 2nd cycle of a stalled write: write, address, and acks go to 0 asynchronously. After reset, a held fetch request is served normally with no ack for the aborted write.
